// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signal bundle for the two-port memory arbiter.
// The arbiter takes the slave view; the requesters/RAM side takes the master view.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [1:0]              reqValid;
  logic [1:0]              reqReady;
  logic [1:0]              reqStore;
  logic [1:0]              reqLock;
  logic [2*ADDR_WIDTH-1:0] reqAddress;
  logic [2*DATA_WIDTH-1:0] reqDataWrite;
  logic [7:0]              reqByteSelect;
  logic [1:0]              rspValid;
  logic [DATA_WIDTH-1:0]   rspData;
  logic [ADDR_WIDTH-1:0]   memAddress;
  logic [DATA_WIDTH-1:0]   memDataWrite;
  logic [3:0]              memByteSelect;
  logic                    memStore;
  logic                    memLoad;
  logic [DATA_WIDTH-1:0]   memDataRead;

  modport slave (
    input  reqValid, reqStore, reqLock, reqAddress, reqDataWrite, reqByteSelect, memDataRead,
    output reqReady, rspValid, rspData, memAddress, memDataWrite, memByteSelect, memStore, memLoad
  );

  modport master (
    output reqValid, reqStore, reqLock, reqAddress, reqDataWrite, reqByteSelect, memDataRead,
    input  reqReady, rspValid, rspData, memAddress, memDataWrite, memByteSelect, memStore, memLoad
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with lock, sharing one synchronous RAM port.
// One access per grant: accept -> strobe cycle -> response cycle.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_arbiter_if.slave         bus,
  output logic [CNT_WIDTH-1:0] grantCount0,
  output logic [CNT_WIDTH-1:0] grantCount1
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                    state_q, state_d;
  logic                      lastGrant_q;
  logic                      lockValid_q;
  logic                      lockOwner_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [3:0]                be_q;
  logic                      store_q;
  logic                      id_q;
  logic [1:0][CNT_WIDTH-1:0] cnt_q;

  logic sel, selValid, lockDrop, accept;

  // Port selection: a live lock pins the choice to its owner; ties alternate.
  always_comb begin
    sel      = 1'b0;
    selValid = 1'b0;
    lockDrop = 1'b0;
    if (lockValid_q) begin
      sel      = lockOwner_q;
      selValid = bus.reqValid[lockOwner_q];
      lockDrop = (state_q == IDLE) && !bus.reqValid[lockOwner_q];
    end else if (&bus.reqValid) begin
      sel      = ~lastGrant_q;
      selValid = 1'b1;
    end else if (bus.reqValid[1]) begin
      sel      = 1'b1;
      selValid = 1'b1;
    end else if (bus.reqValid[0]) begin
      selValid = 1'b1;
    end
  end

  // Ready is also masked by reset so nothing appears accepted while held.
  assign accept       = reset && (state_q != ACCESS) && selValid;
  assign bus.reqReady = accept ? (2'b01 << sel) : 2'b00;

  always_comb begin
    state_d           = state_q;
    bus.memStore      = 1'b0;
    bus.memLoad       = 1'b0;
    bus.memByteSelect = 4'b0000;
    bus.rspValid      = 2'b00;
    bus.rspData       = '0;
    case (state_q)
      IDLE: if (accept) state_d = ACCESS;
      ACCESS: begin
        bus.memStore      = store_q;
        bus.memLoad       = !store_q;
        bus.memByteSelect = store_q ? be_q : 4'b0000;
        state_d           = RESPOND;
      end
      RESPOND: begin
        bus.rspValid = 2'b01 << id_q;
        bus.rspData  = store_q ? '0 : bus.memDataRead;
        state_d      = accept ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastGrant_q <= 1'b1;
      lockValid_q <= 1'b0;
      lockOwner_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= 4'b0000;
      store_q     <= 1'b0;
      id_q        <= 1'b0;
    end else if (accept) begin
      addr_q      <= sel ? bus.reqAddress[ADDR_WIDTH +: ADDR_WIDTH]
                         : bus.reqAddress[0 +: ADDR_WIDTH];
      data_q      <= sel ? bus.reqDataWrite[DATA_WIDTH +: DATA_WIDTH]
                         : bus.reqDataWrite[0 +: DATA_WIDTH];
      be_q        <= !bus.reqStore[sel] ? 4'b0000
                   : sel ? bus.reqByteSelect[7:4] : bus.reqByteSelect[3:0];
      store_q     <= bus.reqStore[sel];
      id_q        <= sel;
      lastGrant_q <= sel;
      lockValid_q <= bus.reqLock[sel];
      lockOwner_q <= sel;
    end else if (lockDrop) begin
      lockValid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (accept && (sel == 1'(i)) && !(&cnt_q[i]))
          cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  assign bus.memAddress   = addr_q;
  assign bus.memDataWrite = data_q;
  assign grantCount0      = cnt_q[0];
  assign grantCount1      = cnt_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model.
// Counter width is narrowed to 4 so saturation is reachable in a few requests.
module tb_mem_arbiter;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] gc0, gc1;
  logic [31:0]   ram [0:15];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(rst_n), .bus(bus), .grantCount0(gc0), .grantCount1(gc1)
  );

  // RAM: load sampled at edge E returns data in the following cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[4]          <= 32'hDEADBEEF;
      ram[8]          <= 32'hAABBCCDD;
      bus.memDataRead <= '0;
    end else begin
      if (bus.memLoad) bus.memDataRead <= ram[bus.memAddress[5:2]];
      if (bus.memStore)
        for (int b = 0; b < 4; b++)
          if (bus.memByteSelect[b])
            ram[bus.memAddress[5:2]][8*b +: 8] <= bus.memDataWrite[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.reqValid      = 2'b00;
    bus.reqStore      = 2'b00;
    bus.reqLock       = 2'b00;
    bus.reqAddress    = {32'h20, 32'h10};
    bus.reqDataWrite  = '0;
    bus.reqByteSelect = 8'h00;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int g0, g1, ng;
  logic [1:0] rsp_seen;
  logic [15:0] gport;
  int gcyc [0:15];

  initial begin
    idle_inputs();
    // Reset state, with both ports requesting
    @(negedge clk);
    bus.reqValid = 2'b11;
    #1;
    chk("rst_ready", bus.reqReady, 2'b00);
    chk("rst_rsp", bus.rspValid, 2'b00);
    chk("rst_strobes", {bus.memStore, bus.memLoad}, 2'b00);
    chk("rst_be", bus.memByteSelect, 4'h0);
    chk("rst_addr", bus.memAddress, 32'h0);
    chk("rst_cnt", {gc1, gc0}, 0);
    bus.reqValid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Port 0 load of 0x10
    @(negedge clk);
    bus.reqValid = 2'b01;
    #1 chk("ld_ready", bus.reqReady, 2'b01);
    @(negedge clk);
    bus.reqValid = 2'b00;
    #1;
    chk("ld_strobe", {bus.memStore, bus.memLoad}, 2'b01);
    chk("ld_addr", bus.memAddress, 32'h10);
    chk("ld_ready_access", bus.reqReady, 2'b00);
    @(negedge clk); #1;
    chk("ld_strobe_off", {bus.memStore, bus.memLoad}, 2'b00);
    chk("ld_rsp", bus.rspValid, 2'b01);
    chk("ld_data", bus.rspData, 32'hDEADBEEF);
    chk("ld_cnt0", gc0, 1);
    @(negedge clk); #1;
    chk("ld_rsp_off", bus.rspValid, 2'b00);

    // Port 1 store, then port 0 reads it back
    @(negedge clk);
    bus.reqValid = 2'b10; bus.reqStore = 2'b10;
    bus.reqDataWrite = {32'h11223344, 32'h0}; bus.reqByteSelect = 8'h30;
    #1 chk("st_ready", bus.reqReady, 2'b10);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("st_strobe", {bus.memStore, bus.memLoad}, 2'b10);
    chk("st_be", bus.memByteSelect, 4'b0011);
    chk("st_addr", bus.memAddress, 32'h20);
    chk("st_wdata", bus.memDataWrite, 32'h11223344);
    @(negedge clk); #1;
    chk("st_rsp", bus.rspValid, 2'b10);
    chk("st_rdata", bus.rspData, 32'h0);
    chk("st_be_off", bus.memByteSelect, 4'b0000);
    @(negedge clk);
    bus.reqValid = 2'b01; bus.reqAddress = {32'h0, 32'h20};
    @(negedge clk);
    idle_inputs();
    #1 chk("rb_be_load", bus.memByteSelect, 4'b0000);
    @(negedge clk); #1;
    chk("rb_data", bus.rspData, 32'hAABB3344);

    // Both ports continuously valid: alternating grants every 2 cycles
    rst_pulse();
    g0 = 0; g1 = 0; ng = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      bus.reqValid = {g1 < 6, g0 < 6};
      #1;
      if (bus.reqReady != 2'b00) begin
        chk("alt_port", bus.reqReady, (ng % 2) ? 2'b10 : 2'b01);
        chk("alt_cycle", c, 2 * ng);
        if (bus.reqReady[1]) g1++; else g0++;
        ng++;
      end
    end
    idle_inputs();
    chk("alt_grants", ng, 12);
    chk("alt_cnt", {gc1, gc0}, {4'd6, 4'd6});

    // Lock: port 0 holds three grants while port 1 waits
    rst_pulse();
    g0 = 0; ng = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.reqValid   = {1'b1, g0 < 3};
      bus.reqLock[0] = (g0 < 2);
      #1;
      if (bus.reqReady != 2'b00 && ng < 16) begin
        gport[ng] = bus.reqReady[1];
        gcyc[ng]  = c;
        if (bus.reqReady[0]) g0++;
        ng++;
      end
    end
    idle_inputs();
    chk("lock_seq", {gport[3], gport[2], gport[1], gport[0]}, 4'b1000);
    chk("lock_gap", gcyc[3], 6);

    // Lock owner drops valid: one dead IDLE cycle, then port 1
    rst_pulse();
    @(negedge clk);
    bus.reqValid = 2'b01; bus.reqLock = 2'b01;
    #1 chk("ldrop_grant0", bus.reqReady, 2'b01);
    @(negedge clk);
    bus.reqValid = 2'b10; bus.reqLock = 2'b00;
    @(negedge clk); #1 chk("ldrop_respond", bus.reqReady, 2'b00);
    @(negedge clk); #1 chk("ldrop_idle", bus.reqReady, 2'b00);
    @(negedge clk); #1 chk("ldrop_resume", bus.reqReady, 2'b10);
    idle_inputs();

    // Asynchronous reset during the strobe cycle
    rst_pulse();
    @(negedge clk);
    bus.reqValid = 2'b01;
    @(negedge clk);
    bus.reqValid = 2'b00;
    #1 chk("arst_pre", bus.memLoad, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("arst_strobe", {bus.memStore, bus.memLoad}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      rsp_seen |= bus.rspValid;
    end
    chk("arst_norsp", rsp_seen, 2'b00);
    chk("arst_cnt", {gc1, gc0}, 0);
    bus.reqValid = 2'b01;
    #1 chk("arst_idle", bus.reqReady, 2'b01);
    bus.reqValid = 2'b00;

    // Saturating counter: 14 grants, then three more hold at all-ones
    rst_pulse();
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      bus.reqValid = 2'b01;
      #1;
      if (c >= 27 && (c % 2) == 1)
        chk("sat_cnt0", gc0, (c >= 29) ? 4'hF : 4'hE);
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
